// File: rtl/calc_pkg.sv
// Shared definitions for the calculator front end and core: sequencer state
// encoding, default debounce length and operation codes.
package calc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_DEB_PRESS = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_REL  = 3'd4
  } seq_state_e;

  // 10 ms at 50 MHz; the counter width must cover it.
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
  localparam int unsigned CNT_W_DEF           = 19;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_ABS = 3'b010;

endpackage

// File: rtl/calc_input_sequencer_key_sync2.sv
// Two-flop synchroniser for the raw pushbutton; both flops reset to the
// released (high) level so a reset never looks like a press.
module key_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/calc_input_sequencer.sv
// Calculator front end: debounces ENTER, snapshots SW/OPSEL into stable
// operand registers and issues a single GO strobe per confirmed press.
module calc_input_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = CNT_W_DEF
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic       KEY_ENTER_N,
  input  logic [7:0] SW,
  input  logic [2:0] OPSEL,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic [2:0] OP,
  output logic       GO,
  output logic       BUSY,
  output logic [7:0] CMD_COUNT
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             key_s;
  seq_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       a_q;
  logic [3:0]       b_q;
  logic [2:0]       op_q;
  logic             go_q;
  logic             busy_q;
  logic [7:0]       cmd_cnt_q;

  key_sync2 u_key_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (RESET_N),
    .d_i    (KEY_ENTER_N),
    .q_o    (key_s)
  );

  // Outputs are written on the edge that enters the state they belong to,
  // so GO is high exactly while in ISSUE and BUSY tracks the state register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      go_q      <= 1'b0;
      busy_q    <= 1'b0;
      cmd_cnt_q <= '0;
    end else begin
      go_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!key_s) begin
            state_q <= ST_DEB_PRESS;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_DEB_PRESS: begin
          if (key_s) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_CAPTURE;
            a_q     <= SW[7:4];
            b_q     <= SW[3:0];
            op_q    <= OPSEL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_CAPTURE: begin
          state_q   <= ST_ISSUE;
          go_q      <= 1'b1;
          cmd_cnt_q <= cmd_cnt_q + 8'd1;
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT_REL;
          cnt_q   <= '0;
        end
        ST_WAIT_REL: begin
          // Any low sample restarts the release window, so bounce never re-arms.
          if (!key_s) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign OP        = op_q;
  assign GO        = go_q;
  assign BUSY      = busy_q;
  assign CMD_COUNT = cmd_cnt_q;

endmodule

// File: tb/tb_calc_input_sequencer.sv
// Self-checking bench for calc_input_sequencer with a short debounce window.
module tb_calc_input_sequencer;
  import calc_pkg::*;

  localparam int D = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_n = 1'b1;
  logic [7:0] sw    = 8'h00;
  logic [2:0] opsel = 3'b000;
  logic [3:0] a, b;
  logic [2:0] op;
  logic       go, busy;
  logic [7:0] cmd;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  calc_input_sequencer #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
    .CLOCK_50    (clk),
    .RESET_N     (rst_n),
    .KEY_ENTER_N (key_n),
    .SW          (sw),
    .OPSEL       (opsel),
    .A           (a),
    .B           (b),
    .OP          (op),
    .GO          (go),
    .BUSY        (busy),
    .CMD_COUNT   (cmd)
  );

  // Reference model: the key is seen two edges late; a press is accepted after
  // D+1 consecutive low samples, GO follows one edge later, then the key must
  // be seen high for D consecutive samples before a new press can start.
  typedef enum {M_READY, M_FIRE, M_SETTLE, M_RELEASE} phase_e;
  phase_e     phase    = M_READY;
  int         low_run  = 0;
  int         high_run = 0;
  logic       sp1 = 1'b1, sp2 = 1'b1, m_seen = 1'b1;
  logic [3:0] ea = 0, eb = 0;
  logic [2:0] eop = 0;
  logic       ego = 0, ebusy = 0;
  logic [7:0] ecmd = 0;
  int         edge_n = 0;
  int         exp_go_total = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase = M_READY; low_run = 0; high_run = 0;
      sp1 = 1'b1; sp2 = 1'b1;
      ea = 0; eb = 0; eop = 0; ego = 0; ebusy = 0; ecmd = 0;
      edge_n = 0;
    end else begin
      edge_n++;
      m_seen = sp2; sp2 = sp1; sp1 = key_n;
      ego = 1'b0;
      case (phase)
        M_READY: begin
          low_run = m_seen ? 0 : low_run + 1;
          if (low_run == D + 1) begin
            ea = sw[7:4]; eb = sw[3:0]; eop = opsel;
            phase = M_FIRE;
          end
        end
        M_FIRE: begin
          ego = 1'b1; ecmd = ecmd + 8'd1; exp_go_total++;
          phase = M_SETTLE;
        end
        M_SETTLE: begin
          phase = M_RELEASE; high_run = 0;
        end
        M_RELEASE: begin
          high_run = m_seen ? high_run + 1 : 0;
          if (high_run == D) begin
            phase = M_READY; low_run = 0;
          end
        end
      endcase
      ebusy = (phase != M_READY) || (low_run != 0);
    end
  end

  // Observation: advance to the next falling edge and record what the DUT shows.
  int mism = 0, go_seen = 0, last_go_edge = -1;

  task automatic tick();
    @(negedge clk);
    if (go === 1'b1) begin
      go_seen++;
      last_go_edge = edge_n;
    end
    if ({a, b, op, go, busy, cmd} !== {ea, eb, eop, ego, ebusy, ecmd}) mism++;
  endtask

  task automatic hold_key(input logic val, input int n);
    key_n = val;
    repeat (n) tick();
  endtask

  task automatic pulse_reset(input logic key_after);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    key_n = key_after;
  endtask

  task automatic press(input logic [7:0] s, input logic [2:0] o, input int lo, input int hi);
    sw = s; opsel = o;
    hold_key(1'b0, lo);
    hold_key(1'b1, hi);
  endtask

  task automatic test_clean_press();
    pulse_reset(1'b0);
    sw = 8'h13; opsel = OP_ADD;
    mism = 0; go_seen = 0; last_go_edge = -1;
    hold_key(1'b0, 30);
    checks++; if (go_seen !== 1) begin failures++; $display("FAIL clean_go_count: got %0d expected 1", go_seen); end
    checks++; if (last_go_edge !== D + 4) begin failures++; $display("FAIL clean_go_edge: got %0d expected %0d", last_go_edge, D + 4); end
    checks++; if (a !== 4'd1) begin failures++; $display("FAIL clean_a: got %0d expected 1", a); end
    checks++; if (b !== 4'd3) begin failures++; $display("FAIL clean_b: got %0d expected 3", b); end
    checks++; if (op !== OP_ADD) begin failures++; $display("FAIL clean_op: got %0d expected 0", op); end
    checks++; if (cmd !== 8'd1) begin failures++; $display("FAIL clean_cmd: got %0d expected 1", cmd); end
    hold_key(1'b1, 5);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL clean_busy_held: got %0d expected 1", busy); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clean_busy_fall: got %0d expected 0", busy); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL clean_model: got %0d diverging cycles expected 0", mism); end
  endtask

  task automatic test_reset();
    hold_key(1'b0, 4);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a !== 4'd0) begin failures++; $display("FAIL reset_a: got %0d expected 0", a); end
    checks++; if (b !== 4'd0) begin failures++; $display("FAIL reset_b: got %0d expected 0", b); end
    checks++; if (op !== 3'd0) begin failures++; $display("FAIL reset_op: got %0d expected 0", op); end
    checks++; if (go !== 1'b0) begin failures++; $display("FAIL reset_go: got %0d expected 0", go); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0d expected 0", busy); end
    checks++; if (cmd !== 8'd0) begin failures++; $display("FAIL reset_cmd: got %0d expected 0", cmd); end
    key_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  task automatic test_press_bounce();
    logic [7:0] s;
    logic [2:0] o;
    s = 8'($urandom_range(1, 255)); o = 3'($urandom);
    press(s, o, 12, 10);
    sw = ~s; opsel = ~o;
    mism = 0; go_seen = 0;
    hold_key(1'b0, 2); hold_key(1'b1, 1); hold_key(1'b0, 2); hold_key(1'b1, 10);
    checks++; if (go_seen !== 0) begin failures++; $display("FAIL bounce_go: got %0d pulses expected 0", go_seen); end
    checks++; if ({a, b} !== s) begin failures++; $display("FAIL bounce_ab: got %02h expected %02h", {a, b}, s); end
    checks++; if (op !== o) begin failures++; $display("FAIL bounce_op: got %0d expected %0d", op, o); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bounce_idle: got busy=%0d expected 0", busy); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL bounce_model: got %0d diverging cycles expected 0", mism); end
  endtask

  task automatic test_release_bounce();
    sw = 8'h80; opsel = OP_ABS;
    go_seen = 0; mism = 0;
    hold_key(1'b0, 12);
    checks++; if (go_seen !== 1) begin failures++; $display("FAIL relb_first_go: got %0d expected 1", go_seen); end
    go_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) sw = 8'hFF;
      hold_key(1'b1, 2);
      hold_key(1'b0, 2);
    end
    hold_key(1'b1, 12);
    checks++; if (go_seen !== 0) begin failures++; $display("FAIL relb_second_go: got %0d expected 0", go_seen); end
    checks++; if (a !== 4'd8) begin failures++; $display("FAIL relb_a: got %0d expected 8", a); end
    checks++; if (b !== 4'd0) begin failures++; $display("FAIL relb_b: got %0d expected 0", b); end
    checks++; if (op !== OP_ABS) begin failures++; $display("FAIL relb_op: got %0d expected 2", op); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL relb_idle: got busy=%0d expected 0", busy); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL relb_model: got %0d diverging cycles expected 0", mism); end
  endtask

  task automatic test_reset_mid_debounce();
    sw = 8'h5A; opsel = OP_SUB;
    hold_key(1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({a, b, op, go, busy, cmd} !== 23'd0) begin failures++; $display("FAIL middeb_clear: got %06h expected 000000", {a, b, op, go, busy, cmd}); end
    tick();
    rst_n = 1'b1;
    mism = 0; go_seen = 0; last_go_edge = -1;
    repeat (20) tick();
    checks++; if (go_seen !== 1) begin failures++; $display("FAIL middeb_go_count: got %0d expected 1", go_seen); end
    checks++; if (last_go_edge !== D + 4) begin failures++; $display("FAIL middeb_go_edge: got %0d expected %0d", last_go_edge, D + 4); end
    checks++; if ({a, b, op} !== {8'h5A, OP_SUB}) begin failures++; $display("FAIL middeb_operands: got %03h expected %03h", {a, b, op}, {8'h5A, OP_SUB}); end
    checks++; if (cmd !== 8'd1) begin failures++; $display("FAIL middeb_cmd: got %0d expected 1", cmd); end
    hold_key(1'b1, 10);
    checks++; if (mism !== 0) begin failures++; $display("FAIL middeb_model: got %0d diverging cycles expected 0", mism); end
  endtask

  task automatic test_random();
    int start_go;
    start_go = exp_go_total;
    mism = 0; go_seen = 0;
    for (int i = 0; i < 60; i++) begin
      key_n = 1'b0;
      for (int k = 0, n = $urandom_range(1, 8); k < n; k++) begin
        sw = 8'($urandom); opsel = 3'($urandom); tick();
      end
      key_n = 1'b1;
      for (int k = 0, n = $urandom_range(1, 7); k < n; k++) begin
        sw = 8'($urandom); opsel = 3'($urandom); tick();
      end
    end
    hold_key(1'b1, 10);
    checks++; if (go_seen !== exp_go_total - start_go) begin failures++; $display("FAIL random_go_count: got %0d expected %0d", go_seen, exp_go_total - start_go); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL random_model: got %0d diverging cycles expected 0", mism); end
  endtask

  task automatic test_wrap();
    pulse_reset(1'b1);
    hold_key(1'b1, 4);
    mism = 0; go_seen = 0;
    for (int i = 1; i <= 256; i++) begin
      press(8'($urandom), 3'($urandom), 9, 7);
      if (i == 255) begin
        checks++; if (cmd !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d expected 255", cmd); end
      end
    end
    checks++; if (cmd !== 8'd0) begin failures++; $display("FAIL wrap_zero: got %0d expected 0", cmd); end
    checks++; if (go_seen !== 256) begin failures++; $display("FAIL wrap_go_count: got %0d expected 256", go_seen); end
    checks++; if (mism !== 0) begin failures++; $display("FAIL wrap_model: got %0d diverging cycles expected 0", mism); end
  endtask

  initial begin
    rst_n = 1'b0;
    key_n = 1'b1;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    test_clean_press();
    test_reset();
    test_press_bounce();
    test_release_bounce();
    test_reset_mid_debounce();
    test_random();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_input_sequencer.md
Name: calc_input_sequencer

Overview:
- Front-end stage of the 4-bit signed calculator. Sits directly upstream of the calculator core and feeds its operand/op inputs.
- Synchronises and debounces the ENTER pushbutton. On each confirmed press it snapshots SW into operands A/B and OPSEL into OP.
- Presents those values as stable registers and emits a one-cycle GO strobe. The core and HEX decoders never see switch bounce or mid-change operands.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required to accept a press or release (10 ms at 50 MHz); minimum 1.
- CNT_W, 19, width of the debounce counter; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES.

Ports:
- CLOCK_50  in  1  system clock, rising edge
- RESET_N  in  1  asynchronous, active-low reset
- KEY_ENTER_N  in  1  raw pushbutton, active-low, asynchronous to CLOCK_50
- SW  in  8  operand switches: SW[7:4] = A, SW[3:0] = B (two's complement)
- OPSEL  in  3  operation select switches
- A  out  4  latched operand A
- B  out  4  latched operand B
- OP  out  3  latched operation code
- GO  out  1  one-cycle strobe: A/B/OP newly valid
- BUSY  out  1  high whenever the FSM is not IDLE
- CMD_COUNT  out  8  count of issued commands, wraps

Behaviour:
- Reset (RESET_N=0, asynchronous) sets:
  - A=0, B=0, OP=0, GO=0, BUSY=0, CMD_COUNT=0
  - state=IDLE, debounce counter=0
  - both synchroniser flops=1 (released)
- Synchroniser: two-flop chain on KEY_ENTER_N produces key_s. The FSM uses only key_s.
- FSM states and transitions:
  - IDLE: key_s=0 -> DEB_PRESS with cnt=0.
  - DEB_PRESS: key_s=1 -> IDLE (bounce rejected, no outputs change). Else if cnt==DEBOUNCE_CYCLES-1 -> CAPTURE; else cnt+1.
  - CAPTURE (1 cycle): A<=SW[7:4], B<=SW[3:0], OP<=OPSEL; then -> ISSUE.
  - ISSUE (1 cycle): GO=1, CMD_COUNT+1 (255 -> 0); then -> WAIT_REL with cnt=0.
  - WAIT_REL: key_s=0 -> cnt=0, stay. key_s=1 and cnt==DEBOUNCE_CYCLES-1 -> IDLE; else cnt+1.
- Latency: KEY_ENTER_N is first sampled low at edge 1 and held. GO is high for exactly the one cycle following edge DEBOUNCE_CYCLES+4. A/B/OP are valid from edge DEBOUNCE_CYCLES+3 and are stable while GO is high.
- GO and all outputs are registered; no combinational path from inputs to outputs.
- One GO per press: a held key never re-issues. Release bounce in WAIT_REL never issues.
- A/B/OP hold their values until the next CAPTURE. SW/OPSEL changes outside CAPTURE are ignored.
- OPSEL is passed through unchanged. All 8 codes are legal here; decoding belongs to the core.
- Reset mid-operation: outputs clear immediately. If the key is still held when RESET_N releases, it is treated as a fresh press: full debounce, then one GO.
- BUSY = (state != IDLE), registered alongside state.

Decomposition:
- calc_pkg holds:
  - FSM state encoding (IDLE, DEB_PRESS, CAPTURE, ISSUE, WAIT_REL)
  - DEBOUNCE_CYCLES default
  - operation code constants shared with the calculator core: OP_ADD=3'b000, OP_SUB=3'b001, OP_ABS=3'b010
- Sub-module key_sync2: the two-flop synchroniser with reset-to-1. The FSM and counter stay in the top.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset: pulse RESET_N low -> all outputs 0, BUSY=0, with no clock edge required.
- Clean press: SW=8'h13, OPSEL=OP_ADD, key held low 30 cycles -> GO high only in the cycle after edge 8; A=1, B=3, OP=0, CMD_COUNT=1, BUSY falls 4 cycles after key_s returns high.
- Press bounce: key low 2 cycles, high 1, low 2, high -> no GO, A/B/OP unchanged, FSM back in IDLE.
- Release bounce plus SW change: after a GO with SW=8'h80 and OPSEL=OP_ABS, toggle the key high/low every 2 cycles, change SW to 8'hFF, then hold high -> no second GO, A=8, B=0, OP=2 retained.
- Reset mid-debounce: assert RESET_N during DEB_PRESS and release it with the key still held -> outputs cleared immediately, exactly one GO after DEBOUNCE_CYCLES+4 edges.
- Wrap: 256 clean presses -> CMD_COUNT reads 0 after the 256th GO, exactly 256 GO pulses counted.
